// File: rtl/mcu_bus_pkg.sv
// Shared constants for the memory-port arbiter: FSM encoding, default bus widths
// and port-select codes.
package mcu_bus_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/arb_starve_pick.sv
// Two-requester grant picker: the data side wins ties until fetch has been passed
// over STARVE_MAX times in a row, then fetch is forced once.
module arb_starve_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic i_elig,
    input  logic d_elig,
    output logic grant_i,
    output logic grant_d
);
    logic [3:0] cnt;
    logic       sat;

    assign sat = (cnt == 4'(STARVE_MAX));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (en) begin
            if (i_elig && d_elig) begin
                grant_i = sat;
                grant_d = ~sat;
            end else begin
                grant_i = i_elig;
                grant_d = d_elig;
            end
        end
    end

    // Only decision cycles move the counter; it holds while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (grant_i || !i_elig)
                cnt <= '0;
            else if (grant_d && !sat)
                cnt <= cnt + 4'd1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports, one
// transaction at a time, and produces the per-port stall requests.
//
// state  | meaning
// IDLE   | no transaction in flight; arbitration happens here
// BUSY_I | fetch transaction waiting for mem_ack
// BUSY_D | data transaction waiting for mem_ack
module mem_port_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);
    logic [1:0] state;
    logic       i_elig;
    logic       d_elig;
    logic       grant_i;
    logic       grant_d;

    // A port's own ready cycle must not re-grant the request it just completed.
    assign i_elig    = i_req & ~i_ready;
    assign d_elig    = d_req & ~d_ready;
    assign stall_if  = i_req & ~i_ready;
    assign stall_mem = d_req & ~d_ready;

    arb_starve_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE),
        .i_elig (i_elig),
        .d_elig (d_elig),
        .grant_i(grant_i),
        .grant_d(grant_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        state     <= BUSY_I;
                    end else if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        i_ready <= 1'b1;
                        i_rdata <= mem_rdata;
                        state   <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboarded read data,
// hand sequences for overlap, reset and idle-ack cases, plus a direct picker check.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem;

    logic pk_en, pk_i, pk_d, pk_gi, pk_gd;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_i[$];
    logic [31:0] q_d[$];
    logic [31:0] i_model = '0;
    logic [31:0] d_model = '0;

    int ack_delay = 0;
    int wait_cnt  = 0;
    bit auto_ack  = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    arb_starve_pick #(.STARVE_MAX(4)) pick (
        .clk(clk), .reset(reset), .en(pk_en), .i_elig(pk_i), .d_elig(pk_d),
        .grant_i(pk_gi), .grant_d(pk_gd)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C01_0004;
            32'h200: return 32'h0000_1234;
            default: return a * 3 + 32'h1111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks after ack_delay waiting cycles, data chosen by address.
    always @(posedge clk) begin
        #2;
        if (auto_ack) begin
            if (mem_req && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_val(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) wait_cnt++;
            end
        end
    end

    // Scoreboard: every ready pulse must match a queued expectation.
    always @(posedge clk) begin
        #1;
        if (i_ready) begin
            if (q_i.size() == 0) check("i_ready_unexpected", {31'd0, i_ready}, 32'd0);
            else check("i_rdata", i_rdata, q_i.pop_front());
        end
        if (d_ready) begin
            if (q_d.size() == 0) check("d_ready_unexpected", {31'd0, d_ready}, 32'd0);
            else check("d_rdata", d_rdata, q_d.pop_front());
        end
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic en, i, d, gi, gd;
    } pvec_t;

    vec_t  vecs[5];
    pvec_t pv[15];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        0, 1'b0, 32'h0,        2};
        vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h0,        1, 1'b0, 32'h0,        3};
        vecs[2] = '{1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        2, 1'b0, 32'h0,        4};
        vecs[4] = '{1'b1, 1'b0, 32'h80,  32'h0,        0, 1'b0, 32'h0,        2};

        pv[0]  = '{1, 1, 1, 0, 1};
        pv[1]  = '{1, 1, 1, 0, 1};
        pv[2]  = '{1, 0, 1, 0, 1};
        pv[3]  = '{1, 1, 1, 0, 1};
        pv[4]  = '{1, 1, 1, 0, 1};
        pv[5]  = '{1, 1, 1, 0, 1};
        pv[6]  = '{1, 1, 1, 0, 1};
        pv[7]  = '{1, 1, 1, 1, 0};
        pv[8]  = '{0, 1, 1, 0, 0};
        pv[9]  = '{1, 1, 1, 0, 1};
        pv[10] = '{1, 1, 1, 0, 1};
        pv[11] = '{1, 1, 1, 0, 1};
        pv[12] = '{1, 1, 1, 0, 1};
        pv[13] = '{1, 1, 1, 1, 0};
        pv[14] = '{1, 1, 0, 1, 0};

        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        pk_en = 0; pk_i = 0; pk_d = 0;
        step(); step(); step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_readies", {30'd0, i_ready, d_ready}, 32'd0);
        reset = 1'b0;
        step();

        // Single-port transactions from the vector table.
        for (int k = 0; k < 5; k++) begin
            ack_delay = vecs[k].delay;
            if (vecs[k].is_d) begin
                d_we = vecs[k].we; d_addr = vecs[k].addr; d_wdata = vecs[k].wdata; d_req = 1'b1;
                if (!vecs[k].we) d_model = mem_val(vecs[k].addr);
                q_d.push_back(d_model);
            end else begin
                i_addr = vecs[k].addr; i_req = 1'b1;
                i_model = mem_val(vecs[k].addr);
                q_i.push_back(i_model);
            end
            #1;
            check($sformatf("v%0d_stall_c0", k), {31'd0, vecs[k].is_d ? stall_mem : stall_if}, 32'd1);
            step();
            check($sformatf("v%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].addr);
            check($sformatf("v%0d_mem_we", k), {31'd0, mem_we}, {31'd0, vecs[k].exp_we});
            if (vecs[k].is_d) check($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].exp_wdata);
            lat = 1;
            while (!(i_ready || d_ready) && lat < 40) begin
                step();
                lat++;
            end
            check($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("v%0d_stall_ready", k), {30'd0, stall_if, stall_mem}, 32'd0);
            i_req = 0; d_req = 0;
            step();
        end

        // Data write arriving while a slow fetch is in flight.
        ack_delay = 3;
        i_addr = 32'h48; i_req = 1'b1;
        i_model = mem_val(32'h48);
        q_i.push_back(i_model);
        step();
        step();
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        q_d.push_back(d_model);
        lat = 0;
        while (!i_ready && lat < 40) begin
            step();
            lat++;
            if (!i_ready) check("A_stall_mem_busy", {31'd0, stall_mem}, 32'd1);
        end
        check("A_i_ready", {31'd0, i_ready}, 32'd1);
        check("A_mem_req_ready_cycle", {31'd0, mem_req}, 32'd0);
        i_req = 1'b0;
        step();
        check("A_d_mem_req", {31'd0, mem_req}, 32'd1);
        check("A_d_mem_we", {31'd0, mem_we}, 32'd1);
        check("A_d_mem_addr", mem_addr, 32'h100);
        check("A_d_mem_wdata", mem_wdata, 32'hDEADBEEF);
        lat = 0;
        while (!d_ready && lat < 40) begin
            step();
            lat++;
        end
        check("A_d_ready", {31'd0, d_ready}, 32'd1);
        check("A_d_rdata_kept", d_rdata, d_model);
        d_req = 1'b0;
        step();

        // Simultaneous requests: data first, fetch granted in the d_ready cycle.
        ack_delay = 0;
        i_addr = 32'h4C; i_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        i_model = mem_val(32'h4C);
        d_model = 32'h1234;
        q_i.push_back(i_model);
        q_d.push_back(d_model);
        step();
        check("B_first_addr", mem_addr, 32'h200);
        check("B_first_we", {31'd0, mem_we}, 32'd0);
        check("B_stall_if_wait", {31'd0, stall_if}, 32'd1);
        step();
        check("B_d_ready", {31'd0, d_ready}, 32'd1);
        check("B_d_rdata", d_rdata, 32'h1234);
        d_req = 1'b0;
        step();
        check("B_fetch_req", {31'd0, mem_req}, 32'd1);
        check("B_fetch_addr", mem_addr, 32'h4C);
        step();
        check("B_i_ready", {31'd0, i_ready}, 32'd1);
        i_req = 1'b0;
        step();

        // Ack with nothing outstanding must be ignored.
        auto_ack = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        step(); step();
        mem_ack = 1'b0;
        check("E_i_rdata", i_rdata, i_model);
        check("E_d_rdata", d_rdata, d_model);
        check("E_readies", {30'd0, i_ready, d_ready}, 32'd0);
        check("E_mem_req", {31'd0, mem_req}, 32'd0);

        // Starvation picker: 4 data grants, forced fetch, counter cleared.
        for (int k = 0; k < 15; k++) begin
            pk_en = pv[k].en; pk_i = pv[k].i; pk_d = pv[k].d;
            #1;
            check($sformatf("P%0d_grants", k), {30'd0, pk_gi, pk_gd}, {30'd0, pv[k].gi, pv[k].gd});
            step();
        end
        pk_en = 0; pk_i = 0; pk_d = 0;

        // Reset while BUSY_D: transaction abandoned, late ack ignored.
        d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        step();
        check("R_busy_req", {31'd0, mem_req}, 32'd1);
        step();
        reset = 1'b1;
        step();
        check("R_mem_req", {31'd0, mem_req}, 32'd0);
        check("R_mem_addr", mem_addr, 32'd0);
        check("R_rdata", i_rdata | d_rdata, 32'd0);
        check("R_d_ready", {31'd0, d_ready}, 32'd0);
        reset = 1'b0;
        d_req = 1'b0;
        i_model = '0; d_model = '0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        step(); step();
        mem_ack = 1'b0;
        check("R_late_ack_d_rdata", d_rdata, 32'd0);
        check("R_late_ack_ready", {30'd0, i_ready, d_ready}, 32'd0);
        check("R_late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        step(); step();

        check("pending_i", q_i.size(), 32'd0);
        check("pending_d", q_d.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data-memory port.
- Issues one transaction at a time, returns read data with a one-cycle ready pulse, and drives the per-port stall requests consumed by the hazard unit.
- Data accesses normally win, because they belong to the older instruction. A starvation counter still guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high until i_ready
i_addr  in  ADDR_W  fetch address; stable while i_req high
i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetched word; holds last value between completions
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = write, 0 = read; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  read data; updated only by reads
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  = i_req & ~i_ready (combinational)
stall_mem  out  1  = d_req & ~d_ready (combinational)

Behaviour:
- State machine states: IDLE, BUSY_I, BUSY_D.
- Reset (synchronous, any state, including mid-transaction):
  - State goes to IDLE and the starvation counter clears to 0.
  - mem_req, mem_we, i_ready and d_ready are 0 on the next edge. mem_addr, mem_wdata, i_rdata and d_rdata clear to 0.
  - An in-flight transaction is abandoned with no ready pulse.
- Eligibility: a port is eligible when its req = 1 and its ready is not high this cycle. The port's own ready cycle therefore never re-grants it.
- Arbitration in IDLE:
  - If both ports are eligible: grant fetch when the counter equals STARVE_MAX, otherwise grant data.
  - If only one port is eligible: grant it.
  - If neither is eligible: stay in IDLE.
- On a grant edge:
  - mem_req goes to 1.
  - mem_addr and mem_wdata load from the granted port.
  - mem_we loads d_we for a data grant, 0 for a fetch grant.
  - State goes to BUSY_D or BUSY_I.
- BUSY_x:
  - mem_* outputs hold until a cycle with mem_ack = 1.
  - On that edge: mem_req goes to 0, mem_we goes to 0, state goes to IDLE, and x_ready pulses for exactly one cycle.
  - i_rdata loads mem_rdata for a fetch grant; d_rdata loads mem_rdata only when the data grant was a read.
- mem_ack received in IDLE is ignored.
- Latency: request first seen in IDLE at cycle 0 → mem_req at cycle 1 → with mem_ack at cycle 1, ready at cycle 2. Throughput is at most one transaction per 2 cycles.
- The ready cycle is itself IDLE, so a grant to the other port can occur in that same cycle.
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_MAX, on each data grant made while fetch is eligible.
  - Clears to 0 on any fetch grant, and on any IDLE cycle where fetch is not eligible.
- Simultaneous requests in IDLE: data wins unless the counter is saturated.
- A request that arrives during BUSY waits for IDLE; its stall output stays high throughout.
- Protocol violation (request dropped before ready) is undefined. A fetch flush must hold i_req until i_ready.

Decomposition:
- Shared package mcu_bus_pkg holds:
  - state encoding constants: IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2;
  - default ADDR_W and DATA_W;
  - port-select constant PORT_I / PORT_D.
- One sub-module: arb_starve_pick. It contains the counter plus the grant decision, taking i_elig and d_elig and returning grant_i and grant_d. It is reusable for future DMA sharing.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x40, mem_ack in the first mem_req cycle with mem_rdata = 0x8C010004 → mem_addr = 0x40, mem_we = 0; i_ready pulses at cycle 2 with i_rdata = 0x8C010004; stall_if = 1 during cycles 0–1 only.
- Data write during fetch:
  - Stimulus: fetch granted, mem_ack delayed 3 cycles; d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF arrives during the fetch.
  - Response: the data transaction starts in the i_ready cycle with mem_we = 1 and mem_wdata = 0xDEADBEEF; d_rdata is unchanged after d_ready.
- Simultaneous requests: i_req and d_req both rise in IDLE (read, mem_rdata = 0x1234) → data granted first; fetch granted in the d_ready cycle; d_rdata = 0x1234.
- Starvation: i_req held with d_req continuously re-asserted, STARVE_MAX = 4, mem_ack immediate → exactly 4 data grants, then one fetch grant, then the counter is back at 0.
- Reset mid-operation: reset = 1 while in BUSY_D before mem_ack → the next cycle shows mem_req = 0, d_ready never pulses, and all outputs are 0; a mem_ack arriving afterwards is ignored.
- Idle ack: mem_ack = 1 with no request outstanding → no ready pulse, and no change to i_rdata or d_rdata.
